// File: rtl/inst_fetch_decode_pkg.sv
// Shared types and constants for the instruction fetch/decode sequencer.
// Optional feature macro used by this slice: IFD_PERF_CNT_EN.
package ifd_pkg;

  localparam int PC_W    = 7;
  localparam int INST_W  = 9;
  localparam int LUT_IDX = 4;
  localparam int LUT_N   = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_RSVD = 3'b011,
    OP_LDR  = 3'b100,
    OP_STR  = 3'b101,
    OP_BR   = 3'b110,
    OP_BRZ  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Branch targets indexed by the low instruction bits; unused slots are 0.
  localparam logic [PC_W-1:0] BR_LUT [LUT_N] = '{
    0: 7'd22, 1: 7'd22, 2: 7'd25, 3: 7'd40,
    4: 7'd46, 5: 7'd44, 6: 7'd51, 7: 7'd59,
    default: 7'd0
  };

endpackage

// File: rtl/inst_fetch_decode_if.sv
// Bus between the fetch/decode sequencer, the instruction ROM and the datapath.
// Carries inst_count_o only when IFD_PERF_CNT_EN is defined.
interface inst_fetch_decode_if;
  import ifd_pkg::*;

  logic              start_i;
  logic [PC_W-1:0]   inst_address_o;
  logic [INST_W-1:0] inst_in_i;
  logic              valid_o;
  logic              ack_i;
  logic              zero_i;
  logic [2:0]        opcode_o;
  logic [2:0]        rd_o;
  logic [2:0]        rs_o;
  logic [5:0]        addr6_o;
  logic              done_o;
  logic              illegal_op_o;
`ifdef IFD_PERF_CNT_EN
  logic [15:0]       inst_count_o;

  modport master (
    output start_i, inst_in_i, ack_i, zero_i,
    input  inst_address_o, valid_o, opcode_o, rd_o, rs_o, addr6_o,
           done_o, illegal_op_o, inst_count_o
  );

  modport slave (
    input  start_i, inst_in_i, ack_i, zero_i,
    output inst_address_o, valid_o, opcode_o, rd_o, rs_o, addr6_o,
           done_o, illegal_op_o, inst_count_o
  );
`else
  modport master (
    output start_i, inst_in_i, ack_i, zero_i,
    input  inst_address_o, valid_o, opcode_o, rd_o, rs_o, addr6_o,
           done_o, illegal_op_o
  );

  modport slave (
    input  start_i, inst_in_i, ack_i, zero_i,
    output inst_address_o, valid_o, opcode_o, rd_o, rs_o, addr6_o,
           done_o, illegal_op_o
  );
`endif

endinterface

// File: rtl/inst_fetch_decode_branch_lut.sv
// Combinational branch-target lookup: LUT index -> absolute PC.
module branch_lut
  import ifd_pkg::*;
(
  input  logic [LUT_IDX-1:0] idx_i,
  output logic [PC_W-1:0]    target_o
);

  assign target_o = BR_LUT[idx_i];

endmodule

// File: rtl/inst_fetch_decode.sv
// Instruction fetch/decode sequencer: owns the PC, latches ROM words into IR,
// presents decoded fields, resolves BR/BRZ and detects program halt.
// IFD_PERF_CNT_EN adds a saturating executed-instruction counter.
module inst_fetch_decode
  import ifd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  inst_fetch_decode_if.slave  bus
);

  localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] ir_q;
  logic              valid_q;
  logic              done_q;
  logic              illegal_q;

  opcode_e           op_s;
  logic [PC_W-1:0]   lut_target_s;
  logic              take_s;
  logic              halt_s;
  logic [PC_W-1:0]   pc_d;
  logic              start_ok_s;

  assign op_s       = opcode_e'(ir_q[8:6]);
  assign start_ok_s = bus.start_i && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  branch_lut u_branch_lut (
    .idx_i    (ir_q[LUT_IDX-1:0]),
    .target_o (lut_target_s)
  );

  // Next-PC and halt detection for the instruction held in IR.
  always_comb begin
    take_s = 1'b0;
    halt_s = 1'b0;
    pc_d   = pc_q;
    case (op_s)
      OP_BR:   take_s = 1'b1;
      OP_BRZ:  take_s = bus.zero_i;
      default: take_s = 1'b0;
    endcase
    if (take_s) begin
      pc_d   = lut_target_s;
      halt_s = (lut_target_s == pc_q);
    end else begin
      pc_d   = pc_q + 7'd1;
      halt_s = (pc_q == PC_MAX);
    end
  end

  // Sequencer FSM with registered PC, IR and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= 7'd0;
      ir_q      <= 9'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          valid_q <= 1'b0;
          if (bus.start_i) begin
            state_q   <= ST_FETCH;
            pc_q      <= 7'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir_q    <= bus.inst_in_i;
          valid_q <= 1'b1;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (bus.ack_i) begin
            valid_q <= 1'b0;
            if (op_s == OP_RSVD) begin
              illegal_q <= 1'b1;
            end
            if (halt_s) begin
              state_q <= ST_HALT;
              done_q  <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              state_q <= ST_FETCH;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_address_o = pc_q;
  assign bus.valid_o        = valid_q;
  assign bus.opcode_o       = ir_q[8:6];
  assign bus.rd_o           = ir_q[5:3];
  assign bus.rs_o           = ir_q[2:0];
  assign bus.addr6_o        = ir_q[5:0];
  assign bus.done_o         = done_q;
  assign bus.illegal_op_o   = illegal_q;

`ifdef IFD_PERF_CNT_EN
  logic [15:0] inst_count_q;

  // Saturating count of instructions acknowledged by the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_count_q <= 16'd0;
    end else if (start_ok_s) begin
      inst_count_q <= 16'd0;
    end else if ((state_q == ST_EXEC) && bus.ack_i && (inst_count_q != 16'hFFFF)) begin
      inst_count_q <= inst_count_q + 16'd1;
    end
  end

  assign bus.inst_count_o = inst_count_q;
`else
  logic unused_start_ok_s;
  assign unused_start_ok_s = start_ok_s;
`endif

endmodule
